second_inst_exmem: RTL
======================

# second_inst_exmem

Lane-2 EX→MEM boundary of the dual-issue core. It takes the lane-2 execute result and destination register, and registers them into the M stage as `write_backM2` / `writeRegM2`. It also holds the last value that left M as `write_backKept2`, so the forwarding unit can still select it (codes 4'b0010 and 4'b1001) across pipeline stalls. It owns the multi-cycle FPU wait for lane 2: it raises a stall request for the FPU latency, then captures the FPU result.

## Interface
Parameters:
- `LAT_W`, default 3: width of the FPU latency field; maximum latency is 2^LAT_W − 1 cycles.

Ports:
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `cal_resultE2`  in  32: lane-2 ALU/FPU result from EX.
- `writeRegE2`  in  6: destination register of the EX instruction.
- `RegWriteE2`  in  1: EX instruction writes a register.
- `FpuOpE2`  in  1: EX instruction is an FPU op (`FPUControlE2[0]`).
- `FpuLatE2`  in  LAT_W: FPU latency in cycles from the decoder; 0 means a combinational result.
- `StallM`  in  1: global stall from the memory side; freezes M and Kept.
- `FlushM`  in  1: kill the instruction entering M.
- `StallFpuE2`  out  1: combinational stall request to the hazard unit.
- `write_backM2`  out  32: M-stage result.
- `writeRegM2`  out  6: M-stage destination register.
- `RegWriteM2`  out  1: M-stage write enable.
- `write_backKept2`  out  32: value held for forwarding.
- `writeRegKept2`  out  6: destination register of the held value.
- `RegWriteKept2`  out  1: the held value is valid.

## Operation
FSM states: IDLE and WAIT; counter `cnt` is LAT_W bits.
- IDLE → WAIT when `FpuOpE2 & RegWriteE2 & FpuLatE2 != 0 & !StallM & !FlushM`; load `cnt ← FpuLatE2 − 1`.
- WAIT with `cnt != 0`: `cnt` decrements each edge where `!StallM`.
- WAIT with `cnt == 0`: the result is valid this cycle; go to IDLE on the next edge where `!StallM`.
- `FlushM` in WAIT: go to IDLE and clear `cnt`; nothing is captured.

`StallFpuE2` = `(IDLE & start condition) | (WAIT & cnt != 0)`.

M register update rules, in priority order:
1. `rst`: all M and Kept outputs go to 0.
2. `FlushM`: `RegWriteM2 ← 0`, `writeRegM2 ← 0`, data is don't-care but driven to 0.
3. `StallM`: hold M.
4. `StallFpuE2`: insert a bubble (`RegWriteM2 ← 0`).
5. Otherwise load the E2 inputs.

Kept register:
- On every edge with `!StallM`, load the current M outputs into Kept.
- During `StallM`, Kept holds.
- `FlushM` does not affect Kept.

Other rules:
- Register 0 is never marked written: force `RegWriteM2 ← 0` when `writeRegE2 == 0`.
- Non-FPU and latency-0 ops load M on the next edge, with no stall.

## Timing
- Reset values: every output is 0, the FSM is in IDLE, and `cnt` is 0.
- An FPU op with latency L ≥ 1 presented in cycle t:
  - `StallFpuE2` is high in cycles t .. t+L−1.
  - It is low in cycle t+L; the result is captured at the end of t+L.
  - Each `StallM` cycle adds one cycle.
- The E2 inputs must remain stable while `StallFpuE2` is high; the upstream stage guarantees this.
- A back-to-back FPU op in cycle t+L+1 starts a new wait with no dead cycle.
- Asserting `rst` mid-wait returns the block to IDLE immediately, with outputs at 0.
- Kept lags M by one non-stalled edge.

## Structure
- Shared package: `FWD_M2 = 4'b0010`, `FWD_KEPT2 = 4'b1001`, the FSM state type, and `LAT_W`.
- One natural sub-module, `fpu_wait_ctr`: the FSM, the counter, and `StallFpuE2`. The pipeline and Kept registers live in the top module.

## Test plan
- ALU op, `cal_resultE2 = 32'h0000_1234`, `writeRegE2 = 5`, `RegWriteE2 = 1` → after 1 edge `write_backM2 = 32'h1234`, `writeRegM2 = 5`, no stall; after the next edge Kept = 32'h1234.
- FPU op with L = 3 and result `32'h3F80_0000` → `StallFpuE2` high for 3 cycles with `RegWriteM2 = 0` bubbles, then M = 32'h3F80_0000.
- FPU op with L = 2, `StallM` pulsed for 1 cycle mid-wait → stall lasts 3 cycles; M and Kept are frozen during the pulse.
- `FlushM` asserted in WAIT with `cnt = 1` → FSM to IDLE, `StallFpuE2` drops, `RegWriteM2 = 0`.
- `writeRegE2 = 0` with `RegWriteE2 = 1` → `RegWriteM2 = 0`.
- `rst` asserted asynchronously mid-wait → all outputs 0 without waiting for a clock edge, `StallFpuE2 = 0`.

Source files
------------

// File: rtl/second_inst_exmem_pkg.sv
// Shared definitions for the lane-2 EX/MEM boundary: forwarding select codes,
// the FPU wait FSM state type and the default FPU latency field width.
package second_inst_exmem_pkg;

    localparam logic [3:0]  FWD_M2    = 4'b0010;
    localparam logic [3:0]  FWD_KEPT2 = 4'b1001;
    localparam int unsigned LAT_W     = 3;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } fpu_state_t;

endpackage

// File: rtl/second_inst_exmem_fpu_wait_ctr.sv
// Lane-2 multi-cycle FPU wait: FSM plus latency counter, producing the
// combinational stall request seen by the hazard unit.
module fpu_wait_ctr #(
    parameter int unsigned LAT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             FpuOpE2,
    input  logic             RegWriteE2,
    input  logic [LAT_W-1:0] FpuLatE2,
    input  logic             StallM,
    input  logic             FlushM,
    output logic             StallFpuE2
);
    import second_inst_exmem_pkg::*;

    fpu_state_t       state, state_d;
    logic [LAT_W-1:0] cnt, cnt_d;
    logic             start;

    // Gating with rst keeps the stall request low while reset is held.
    assign start = FpuOpE2 & RegWriteE2 & (FpuLatE2 != '0) & !StallM & !FlushM & !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        StallFpuE2 = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d    = WAIT;
                    cnt_d      = FpuLatE2 - LAT_W'(1);
                    StallFpuE2 = 1'b1;
                end
            end
            WAIT: begin
                StallFpuE2 = (cnt != '0);
                if (FlushM) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!StallM) begin
                    if (cnt != '0) cnt_d = cnt - LAT_W'(1);
                    else           state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/second_inst_exmem.sv
// Lane-2 EX->MEM pipeline register with a one-edge-delayed "Kept" copy for
// forwarding across stalls, and the lane-2 FPU latency wait.
module second_inst_exmem #(
    parameter int unsigned LAT_W = second_inst_exmem_pkg::LAT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      cal_resultE2,
    input  logic [5:0]       writeRegE2,
    input  logic             RegWriteE2,
    input  logic             FpuOpE2,
    input  logic [LAT_W-1:0] FpuLatE2,
    input  logic             StallM,
    input  logic             FlushM,
    output logic             StallFpuE2,
    output logic [31:0]      write_backM2,
    output logic [5:0]       writeRegM2,
    output logic             RegWriteM2,
    output logic [31:0]      write_backKept2,
    output logic [5:0]       writeRegKept2,
    output logic             RegWriteKept2
);

    fpu_wait_ctr #(
        .LAT_W(LAT_W)
    ) u_fpu_wait_ctr (
        .clk        (clk),
        .rst        (rst),
        .FpuOpE2    (FpuOpE2),
        .RegWriteE2 (RegWriteE2),
        .FpuLatE2   (FpuLatE2),
        .StallM     (StallM),
        .FlushM     (FlushM),
        .StallFpuE2 (StallFpuE2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_backM2    <= '0;
            writeRegM2      <= '0;
            RegWriteM2      <= 1'b0;
            write_backKept2 <= '0;
            writeRegKept2   <= '0;
            RegWriteKept2   <= 1'b0;
        end else begin
            if (FlushM) begin
                write_backM2 <= '0;
                writeRegM2   <= '0;
                RegWriteM2   <= 1'b0;
            end else if (!StallM) begin
                if (StallFpuE2) begin
                    RegWriteM2 <= 1'b0;
                end else begin
                    write_backM2 <= cal_resultE2;
                    writeRegM2   <= writeRegE2;
                    RegWriteM2   <= RegWriteE2 & (writeRegE2 != '0);
                end
            end
            // Kept samples the pre-edge M contents, so it trails M by one advancing edge.
            if (!StallM) begin
                write_backKept2 <= write_backM2;
                writeRegKept2   <= writeRegM2;
                RegWriteKept2   <= RegWriteM2;
            end
        end
    end

endmodule
